cache_tag_lookup: RTL and testbench
===================================

// Module: cache_tag_lookup
// PURPOSE
// Direct-mapped tag/valid/data lookup stage directly upstream of cache_controller.
// Accepts CPU read requests, compares tags, drives registered hit into the controller, and returns read data.
// On a miss it refills the whole line from memory over a req/ack handshake, then replays the lookup.
// PARAMETERS
// ADDR_W    32  byte-address width; addr[1:0] ignored (word access only)
// DATA_W    32  word width
// INDEX_W   4   line index bits (16 lines)
// OFFSET_W  2   word-in-line bits (4 words/line); TAG_W = ADDR_W-INDEX_W-OFFSET_W-2
// PORTS
// clk          in   1       single clock, rising edge
// rst_n        in   1       asynchronous active-low reset
// req_valid    in   1       CPU read request
// req_addr     in   ADDR_W  byte address, sampled when req_valid && req_ready
// req_ready    out  1       lookup can accept a request (IDLE only, no flush)
// flush        in   1       invalidate all lines
// hit          out  1       registered 1-cycle pulse to cache_controller on a lookup hit
// rdata        out  DATA_W  read word, valid with rdata_valid
// rdata_valid  out  1       1-cycle pulse, coincident with hit
// mem_req      out  1       refill word request
// mem_addr     out  ADDR_W  refill word address {tag,index,cnt,2'b00}
// mem_ack      in   1       memory returns mem_rdata this cycle
// mem_rdata    in   DATA_W  refill word
// miss_cnt     out  16      saturating count of lookup misses
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, all valid bits 0, hit/rdata_valid/mem_req 0, rdata 0, mem_addr 0, miss_cnt 0, refill cnt 0.
// - FSM IDLE -> COMPARE -> (RESP | REFILL); REFILL -> COMPARE; RESP -> IDLE.
// - IDLE: req_ready=1 unless flush=1. flush in IDLE clears all valid bits next edge; flush+req_valid same cycle: flush wins, req not accepted.
//   flush outside IDLE is ignored (requester must hold it).
// - Accept at edge N -> COMPARE during cycle N+1. Hit = valid[index] && tag_arr[index]==tag.
// - Hit: hit=1, rdata_valid=1, rdata=data[index][offset] registered, visible cycle N+2 for exactly one cycle (RESP); IDLE at N+3.
// - Miss: miss_cnt+1 (saturates at 16'hFFFF), valid[index] cleared, tag_arr[index] written, cnt=0, enter REFILL.
// - REFILL: mem_req=1 continuously; mem_addr held stable until mem_ack; on mem_ack write mem_rdata to data[index][cnt], cnt++.
//   Ack with cnt==2^OFFSET_W-1: valid[index]=1, mem_req=0 next cycle, -> COMPARE (replay, guaranteed hit).
// - Miss latency with zero-wait memory: accept N, COMPARE N+1, refill N+2..N+5, COMPARE N+6, hit pulse N+7.
// - Partially refilled line never hits (valid cleared for whole refill). Refill always fetches words 0..last in order.
// - Reset mid-refill: refill aborted, line stays invalid, mem_req drops immediately.
// - hit and rdata_valid never asserted outside RESP; req_ready=0 in COMPARE/REFILL/RESP.
// - Data array: 2^(INDEX_W+OFFSET_W) words, no reset required (gated by valid).
// TESTING
// - Reset then read 0x0000_0040 with mem_rdata=addr -> 4 mem_req beats at 0x40,0x44,0x48,0x4C, hit pulse, rdata=0x40, miss_cnt=1.
// - Re-read 0x0000_0044 after refill -> hit & rdata_valid exactly at accept+2, rdata=0x44, no mem_req, miss_cnt=1.
// - Read 0x0000_0440 (same index, new tag) then 0x0000_0040 -> both miss, miss_cnt=3, second returns 0x40.
// - mem_ack delayed 3 cycles per beat -> mem_addr stable while waiting, rdata correct, one hit pulse only.
// - flush with req_valid same cycle -> req_ready=0, request held, next lookup of 0x40 misses.
// - rst_n low during 3rd refill beat -> mem_req=0 at once, state IDLE; re-read 0x44 misses and refills full line.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// Direct-mapped tag/valid/data lookup with whole-line refill on miss.
// Ports: CPU req (req_valid/req_addr/req_ready), flush, hit/rdata/rdata_valid,
//        refill (mem_req/mem_addr/mem_ack/mem_rdata), miss_cnt.
module cache_tag_lookup #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);
  localparam logic [OFFSET_W-1:0] CNT_ONE  = 1;
  localparam logic [OFFSET_W-1:0] CNT_LAST = '1;
  localparam logic [OFFSET_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    REFILL,
    RESP
  } state_t;

  state_t              state;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic [OFFSET_W-1:0] cnt;
  logic [OFFSET_W-1:0] cnt_nxt;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_arr [LINES];
  logic [DATA_W-1:0]   data_arr [WORDS];
  logic                lookup_hit;
  logic                unused_ok;

  // Word access only: byte-select bits are don't-care.
  assign unused_ok  = ^req_addr[1:0];
  assign req_ready  = (state == IDLE) && !flush;
  assign lookup_hit = valid[idx_q] && (tag_arr[idx_q] == tag_q);
  assign cnt_nxt    = cnt + CNT_ONE;

  // Tag and data storage need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (state == COMPARE && !lookup_hit)
      tag_arr[idx_q] <= tag_q;
    if (state == REFILL && mem_ack)
      data_arr[{idx_q, cnt}] <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      cnt         <= '0;
      valid       <= '0;
      hit         <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      miss_cnt    <= '0;
    end else begin
      hit         <= 1'b0;
      rdata_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (req_valid) begin
            tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            idx_q <= req_addr[OFFSET_W+2 +: INDEX_W];
            off_q <= req_addr[2 +: OFFSET_W];
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (lookup_hit) begin
            hit         <= 1'b1;
            rdata_valid <= 1'b1;
            rdata       <= data_arr[{idx_q, off_q}];
            state       <= RESP;
          end else begin
            if (miss_cnt != 16'hFFFF)
              miss_cnt <= miss_cnt + 16'd1;
            // Line stays invalid until its last word lands.
            valid[idx_q] <= 1'b0;
            cnt          <= '0;
            mem_req      <= 1'b1;
            mem_addr     <= {tag_q, idx_q, CNT_ZERO, 2'b00};
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt      <= cnt_nxt;
            mem_addr <= {tag_q, idx_q, cnt_nxt, 2'b00};
            if (cnt == CNT_LAST) begin
              valid[idx_q] <= 1'b1;
              mem_req      <= 1'b0;
              state        <= COMPARE;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Bench for cache_tag_lookup: table vectors, corner sequences,
// random reads against a line-level reference model.
module tb_cache_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        hit;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  int mem_delay = 0;
  logic [31:0] beats[$];

  bit          mvalid [16];
  logic [23:0] mtag   [16];
  int          mmiss;

  always #5 clk = ~clk;

  cache_tag_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .hit(hit), .rdata(rdata), .rdata_valid(rdata_valid),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .miss_cnt(miss_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Memory: returns the word address as data, after mem_delay idle cycles.
  initial begin
    int  wait_cnt;
    bit  waiting;
    logic [31:0] hold_addr;
    mem_ack = 0; mem_rdata = 0;
    wait_cnt = 0; waiting = 0; hold_addr = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (waiting) chk("mem_addr_hold", mem_addr, hold_addr);
        if (wait_cnt >= mem_delay) begin
          mem_ack   = 1;
          mem_rdata = mem_addr;
          beats.push_back(mem_addr);
          wait_cnt = 0;
          waiting  = 0;
        end else begin
          mem_ack   = 0;
          wait_cnt++;
          waiting   = 1;
          hold_addr = mem_addr;
        end
      end else begin
        mem_ack  = 0;
        wait_cnt = 0;
        waiting  = 0;
      end
    end
  end

  task automatic model_clear();
    foreach (mvalid[i]) mvalid[i] = 0;
  endtask

  task automatic model_read(input logic [31:0] a, output bit h);
    int i;
    i = int'(a[7:4]);
    h = mvalid[i] && mtag[i] == a[31:8];
    if (!h) begin
      mvalid[i] = 1;
      mtag[i]   = a[31:8];
      if (mmiss < 65535) mmiss++;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int d,
                         input bit eh, input logic [15:0] emc);
    int n;
    int exp_edges;
    logic [31:0] base;
    mem_delay = d;
    beats.delete();
    @(negedge clk);
    req_valid = 1;
    req_addr  = a;
    #1 chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 0;
    exp_edges = eh ? 1 : 2 + 4 * (d + 1);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!hit && n < 300);
    chk("latency", n, exp_edges);
    chk("rdata_valid", 32'(rdata_valid), 32'd1);
    chk("rdata", rdata, {a[31:2], 2'b00});
    chk("miss_cnt", 32'(miss_cnt), 32'(emc));
    @(posedge clk);
    #1 chk("hit_single", 32'(hit | rdata_valid), 32'd0);
    chk("beat_count", beats.size(), eh ? 0 : 4);
    base = {a[31:4], 4'b0};
    foreach (beats[i]) chk("beat_addr", beats[i], base + 32'(4 * i));
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1;
    #1 chk("ready_flush", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 0;
    model_clear();
  endtask

  typedef struct {
    logic [31:0] addr;
    int          dly;
    bit          h;
    logic [15:0] mc;
  } vec_t;

  vec_t tv [11];

  initial begin
    bit h;
    logic [31:0] a;
    tv[0]  = '{32'h0000_0040, 0, 0, 16'd1};
    tv[1]  = '{32'h0000_0044, 0, 1, 16'd1};
    tv[2]  = '{32'h0000_0440, 0, 0, 16'd2};
    tv[3]  = '{32'h0000_0040, 0, 0, 16'd3};
    tv[4]  = '{32'h0000_004C, 0, 1, 16'd3};
    tv[5]  = '{32'h0000_0080, 3, 0, 16'd4};
    tv[6]  = '{32'h0000_0088, 0, 1, 16'd4};
    tv[7]  = '{32'h0000_7FFC, 1, 0, 16'd5};
    tv[8]  = '{32'h0000_7FF0, 0, 1, 16'd5};
    tv[9]  = '{32'hFFFF_FFFF, 0, 0, 16'd6};
    tv[10] = '{32'h0000_7FF3, 0, 0, 16'd7};

    rst_n = 0; req_valid = 0; req_addr = 0; flush = 0;
    model_clear();
    mmiss = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 11; k++) begin
      model_read(tv[k].addr, h);
      do_read(tv[k].addr, tv[k].dly, tv[k].h, tv[k].mc);
    end

    // Flush and request together: flush wins, request not taken.
    @(negedge clk);
    flush = 1; req_valid = 1; req_addr = 32'h40;
    #1 chk("flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    flush = 0; req_valid = 0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk("flush_no_accept", 32'(mem_req | hit), 32'd0);
    end
    model_read(32'h40, h);
    do_read(32'h40, 0, h, 16'(mmiss));
    chk("flush_then_miss", 32'(h), 32'd0);

    // Reset during the third refill beat.
    mem_delay = 0;
    beats.delete();
    @(negedge clk);
    req_valid = 1; req_addr = 32'h0000_1044;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rstmid_beats", beats.size(), 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_clear();
    mmiss = 0;
    model_read(32'h0000_1044, h);
    do_read(32'h0000_1044, 0, h, 16'(mmiss));
    chk("rstmid_replay_miss", 32'(h), 32'd0);

    // Random reads over a small tag set so hits and evictions mix.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(7) == 0) do_flush();
      a = {22'd0, 2'($urandom_range(2)), 4'($urandom_range(15)),
           2'($urandom_range(3)), 2'($urandom_range(3))};
      model_read(a, h);
      do_read(a, int'($urandom_range(2)), h, 16'(mmiss));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
